stopwatch_lap_core: RTL and testbench

//  Parametrised stopwatch, MM:SS.cc, counting centiseconds from the board clock.

---
 rtl/stopwatch_lap_core_pkg.sv | 47 ++++
 rtl/stopwatch_lap_core_bcd_mod_counter.sv | 46 ++++
 rtl/stopwatch_lap_core.sv | 172 +++++++++++++++++
 tb/tb_stopwatch_lap_core.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/stopwatch_lap_core_pkg.sv
// Shared types and constants for the lap stopwatch: FSM states, time record,
// 7-segment patterns (bit0=a .. bit6=g) and the BCD-to-segment decoder.
package stopwatch_lap_core_pkg;
  localparam int DIG_W = 4;
  localparam int SEG_W = 7;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_LAP, ST_STOP} sw_state_e;

  typedef struct packed {
    logic [DIG_W-1:0] m10;
    logic [DIG_W-1:0] m1;
    logic [DIG_W-1:0] s10;
    logic [DIG_W-1:0] s1;
    logic [DIG_W-1:0] c10;
    logic [DIG_W-1:0] c1;
  } sw_time_t;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  function automatic logic [SEG_W-1:0] bcd2seg(input logic [DIG_W-1:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/stopwatch_lap_core_bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MOD-1; carry is combinational so a chain
// of these advances in the same cycle as the enabling tick.
module bcd_mod_counter
  import stopwatch_lap_core_pkg::*;
#(
  parameter int MOD = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [DIG_W-1:0] o_tens,
  output logic [DIG_W-1:0] o_units,
  output logic             o_carry
);
  localparam logic [DIG_W-1:0] LAST_T = DIG_W'((MOD - 1) / 10);
  localparam logic [DIG_W-1:0] LAST_U = DIG_W'((MOD - 1) % 10);

  logic [DIG_W-1:0] r_tens, r_units;
  logic             w_last;

  assign w_last  = (r_tens == LAST_T) && (r_units == LAST_U);
  assign o_carry = i_en & w_last;
  assign o_tens  = r_tens;
  assign o_units = r_units;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tens  <= '0;
      r_units <= '0;
    end else if (i_clr) begin
      r_tens  <= '0;
      r_units <= '0;
    end else if (i_en) begin
      if (w_last) begin
        r_tens  <= '0;
        r_units <= '0;
      end else if (r_units == 4'd9) begin
        r_units <= '0;
        r_tens  <= r_tens + 4'd1;
      end else begin
        r_units <= r_units + 4'd1;
      end
    end
  end
endmodule

// File: rtl/stopwatch_lap_core.sv
// MM:SS.cc stopwatch with debounced start/stop and lap buttons, lap freeze and
// clear-from-stopped; drives six registered 7-segment digits.
module stopwatch_lap_core
  import stopwatch_lap_core_pkg::*;
#(
  parameter int TICK_DIV       = 500000,
  parameter int DB_CYC         = 1000000,
  parameter int MIN_MAX        = 60,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_stop,
  input  logic             lap,
  output logic [SEG_W-1:0] m10,
  output logic [SEG_W-1:0] m1,
  output logic [SEG_W-1:0] s10,
  output logic [SEG_W-1:0] s1,
  output logic [SEG_W-1:0] c10,
  output logic [SEG_W-1:0] c1,
  output logic             running,
  output logic             lap_active,
  output logic             wrapped
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LW = $clog2(DB_CYC + 1);
  localparam logic [SEG_W-1:0] SEG_MASK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  // ---- button conditioning: sync, edge detect, per-button lockout ----
  logic [1:0] w_btn, w_press;
  assign w_btn = {lap, start_stop};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic          r_s1, r_s2, r_prev;
    logic [LW-1:0] r_lock;
    assign w_press[gi] = r_s2 & ~r_prev & (r_lock == '0);
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_s1   <= 1'b0;
        r_s2   <= 1'b0;
        r_prev <= 1'b0;
        r_lock <= '0;
      end else begin
        r_s1   <= w_btn[gi];
        r_s2   <= r_s1;
        r_prev <= r_s2;
        if (w_press[gi])        r_lock <= LW'(DB_CYC);
        else if (r_lock != '0)  r_lock <= r_lock - 1'b1;
      end
    end
  end

  logic w_ss, w_lp;
  assign w_ss = w_press[0];
  assign w_lp = w_press[1];

  // ---- control FSM ----
  sw_state_e r_state, w_state_nxt;
  logic      w_clr, w_latch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: if (w_ss) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_ss) w_state_nxt = ST_STOP;
        else if (w_lp) begin
          w_state_nxt = ST_LAP;
          w_latch     = 1'b1;
        end
      end
      ST_LAP: begin
        if (w_ss)      w_state_nxt = ST_STOP;
        else if (w_lp) w_state_nxt = ST_RUN;
      end
      ST_STOP: begin
        if (w_ss) w_state_nxt = ST_RUN;
        else if (w_lp) begin
          w_state_nxt = ST_IDLE;
          w_clr       = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---- prescaler: frozen outside RUN/LAP so pause keeps sub-tick phase ----
  logic          w_active, w_tick;
  logic [PW-1:0] r_presc;

  assign w_active = (r_state == ST_RUN) || (r_state == ST_LAP);
  assign w_tick   = w_active && (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_presc <= '0;
    else if (w_clr)    r_presc <= '0;
    else if (w_tick)   r_presc <= '0;
    else if (w_active) r_presc <= r_presc + 1'b1;
  end

  // ---- time chain ----
  sw_time_t w_live;
  logic     w_cc_cy, w_ss_cy, w_mm_cy;

  bcd_mod_counter #(.MOD(100)) u_cc (
    .clk(clk), .rst(rst), .i_en(w_tick), .i_clr(w_clr),
    .o_tens(w_live.c10), .o_units(w_live.c1), .o_carry(w_cc_cy));

  bcd_mod_counter #(.MOD(60)) u_ss (
    .clk(clk), .rst(rst), .i_en(w_cc_cy), .i_clr(w_clr),
    .o_tens(w_live.s10), .o_units(w_live.s1), .o_carry(w_ss_cy));

  bcd_mod_counter #(.MOD(MIN_MAX)) u_mm (
    .clk(clk), .rst(rst), .i_en(w_ss_cy), .i_clr(w_clr),
    .o_tens(w_live.m10), .o_units(w_live.m1), .o_carry(w_mm_cy));

  logic     r_wrapped;
  sw_time_t r_lap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrapped <= 1'b0;
      r_lap     <= '0;
    end else begin
      if (w_clr)        r_wrapped <= 1'b0;
      else if (w_mm_cy) r_wrapped <= 1'b1;
      if (w_clr)        r_lap <= '0;
      else if (w_latch) r_lap <= w_live;
    end
  end

  // ---- display: source mux and decode in one register stage ----
  sw_time_t         w_disp;
  logic [SEG_W-1:0] r_m10, r_m1, r_s10, r_s1, r_c10, r_c1;

  assign w_disp = (r_state == ST_LAP) ? r_lap : w_live;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m10 <= SEG_0 ^ SEG_MASK;
      r_m1  <= SEG_0 ^ SEG_MASK;
      r_s10 <= SEG_0 ^ SEG_MASK;
      r_s1  <= SEG_0 ^ SEG_MASK;
      r_c10 <= SEG_0 ^ SEG_MASK;
      r_c1  <= SEG_0 ^ SEG_MASK;
    end else begin
      r_m10 <= bcd2seg(w_disp.m10) ^ SEG_MASK;
      r_m1  <= bcd2seg(w_disp.m1)  ^ SEG_MASK;
      r_s10 <= bcd2seg(w_disp.s10) ^ SEG_MASK;
      r_s1  <= bcd2seg(w_disp.s1)  ^ SEG_MASK;
      r_c10 <= bcd2seg(w_disp.c10) ^ SEG_MASK;
      r_c1  <= bcd2seg(w_disp.c1)  ^ SEG_MASK;
    end
  end

  assign m10        = r_m10;
  assign m1         = r_m1;
  assign s10        = r_s10;
  assign s1         = r_s1;
  assign c10        = r_c10;
  assign c1         = r_c1;
  assign running    = w_active;
  assign lap_active = (r_state == ST_LAP);
  assign wrapped    = r_wrapped;
endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Directed bench for stopwatch_lap_core (TICK_DIV=4, DB_CYC=8, MIN_MAX=2);
// stimulus queues expected display/status, a negedge monitor pops and compares.
module tb_stopwatch_lap_core;
  logic       clk = 1'b0;
  logic       rst, start_stop, lap;
  logic [6:0] m10, m1, s10, s1, c10, c1;
  logic       running, lap_active, wrapped;

  stopwatch_lap_core #(
    .TICK_DIV(4), .DB_CYC(8), .MIN_MAX(2), .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .lap(lap),
    .m10(m10), .m1(m1), .s10(s10), .s1(s1), .c10(c10), .c1(c1),
    .running(running), .lap_active(lap_active), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [41:0] segs;
    logic        run;
    logic        lapa;
    logic        wr;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [6:0] seg(input int d);
    return seg_tbl[d];
  endfunction

  // monitor: the display is always presenting, so every queued entry is
  // compared at the first falling edge after it was queued
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [41:0] got;
      e   = q.pop_front();
      got = {m10, m1, s10, s1, c10, c1};
      n_chk++;
      if (got !== e.segs || running !== e.run || lap_active !== e.lapa || wrapped !== e.wr) begin
        n_fail++;
        $display("FAIL %s: got seg=%h run=%b lap=%b wr=%b, want seg=%h run=%b lap=%b wr=%b",
                 e.name, got, running, lap_active, wrapped, e.segs, e.run, e.lapa, e.wr);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic s, input logic l);
    start_stop = s;
    lap        = l;
    tick(3);
    start_stop = 1'b0;
    lap        = 1'b0;
  endtask

  task automatic chk(input string nm, input int mm, input int ss, input int cc,
                     input logic r, input logic l, input logic w);
    exp_t e;
    e.name = nm;
    e.segs = {seg(mm / 10), seg(mm % 10), seg(ss / 10), seg(ss % 10), seg(cc / 10), seg(cc % 10)};
    e.run  = r;
    e.lapa = l;
    e.wr   = w;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; start_stop = 1'b0; lap = 1'b0;
    tick(3);
    chk("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick(2);

    // start; 100 ticks of 4 clk each
    press(1, 0);  chk("start",   0, 0, 0,  1, 0, 0);
    tick(400);    chk("run_99",  0, 0, 99, 1, 0, 0);
    tick(1);      chk("run_100", 0, 1, 0,  1, 0, 0);

    // stop with prescaler at phase 1, hold, resume from that phase
    tick(1); press(1, 0); chk("stop", 0, 1, 1, 0, 0, 0);
    tick(100);            chk("hold", 0, 1, 1, 0, 0, 0);
    press(1, 0);          chk("resume",  0, 1, 1, 1, 0, 0);
    tick(3);              chk("phase_a", 0, 1, 1, 1, 0, 0);
    tick(1);              chk("phase_b", 0, 1, 2, 1, 0, 0);

    // stop then clear
    tick(10); press(1, 0); press(0, 1); tick(1);
    chk("clear", 0, 0, 0, 0, 0, 0);

    // lap freeze at 00:00.37
    tick(10); press(1, 0);
    tick(147); press(0, 1); chk("lap_enter",   0, 0, 37, 1, 1, 0);
    tick(40);               chk("lap_frozen",  0, 0, 37, 1, 1, 0);
    press(0, 1); tick(1);   chk("lap_release", 0, 0, 48, 1, 0, 0);

    // bouncing start/stop: three rising edges inside the lockout
    start_stop = 1'b1; tick(1); start_stop = 1'b0; tick(1);
    start_stop = 1'b1; tick(1); start_stop = 1'b0; tick(1);
    start_stop = 1'b1; tick(1); start_stop = 1'b0;
    tick(10); chk("bounce", 0, 0, 49, 0, 0, 0);

    // simultaneous presses from RUN: start/stop wins
    press(1, 0);
    tick(10); press(1, 1); tick(1); chk("ss_lap_same", 0, 0, 52, 0, 0, 0);
    tick(10);                       chk("same_hold",   0, 0, 52, 0, 0, 0);

    // full wrap at 01:59.99
    press(0, 1); tick(10); press(1, 0);
    tick(47999);          chk("pre_wrap",     1, 59, 99, 1, 0, 0);
    tick(2);              chk("wrap",         0, 0,  0,  1, 0, 1);
    press(1, 0); tick(1); chk("stop_wrapped", 0, 0,  1,  0, 0, 1);
    press(0, 1); tick(1); chk("clear_wrap",   0, 0,  0,  0, 0, 0);

    // asynchronous reset while in LAP
    tick(10); press(1, 0); tick(10); press(0, 1);
    chk("lap_pre_rst", 0, 0, 3, 1, 1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_lap", 0, 0, 0, 0, 0, 0);
    tick(2); rst = 1'b1; tick(2);
    chk("post_rst", 0, 0, 0, 0, 0, 0);

    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
